data_bus_arbiter: RTL

Shares the single peripheral data bus between the core datapath and a DMA requester. Sits between the datapath's data-bus control outputs and the peripheral bus decode, issuing one transfer at a time. Reads use the core's two-cycle load protocol: a setup cycle, then a sample cycle. A starvation counter bounds how long the core can lock out the DMA.

---
 rtl/bus_pkg.sv | 38 +++
 rtl/bus_grant_arbiter.sv | 51 +++++
 rtl/data_bus_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral data-bus arbiter: mode, width and owner codes, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package bus_pkg;

    localparam logic [1:0] BUS_IDLE  = 2'b00;
    localparam logic [1:0] BUS_READ  = 2'b01;
    localparam logic [1:0] BUS_WRITE = 2'b10;

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CORE = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        SAMPLE = 2'b10
    } state_e;

    // One master's complete request, latched as a unit at grant.
    typedef struct packed {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  reqw;
        logic        reqs;
    } req_t;

    // Mode 11 is treated as idle, so only the two real transfer codes count as a request.
    function automatic logic is_req(input logic [1:0] mode);
        return (mode == BUS_READ) || (mode == BUS_WRITE);
    endfunction

endpackage

// File: rtl/bus_grant_arbiter.sv
// Picks core or DMA as the next bus owner; a starvation counter forces the DMA through after STARVE_LIMIT contended core wins.
// Latency: grant outputs are combinational; the counter advances on the grant strobe edge.
// Backpressure: none of its own; the loser simply stays un-granted until the next strobe.
module bus_grant_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic core_req,
    input  logic dma_req,
    input  logic grant_stb,
    output logic grant_core,
    output logic grant_dma
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    // Winner selection: core has priority unless the DMA has been starved to the limit.
    always_comb begin
        grant_dma  = dma_req & (~core_req | (starve_cnt_q == LIMIT));
        grant_core = core_req & ~grant_dma;
    end

    // Count contended core wins (saturating); any DMA grant clears the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_stb) begin
            if (grant_dma) begin
                starve_cnt_d = '0;
            end else if (grant_core && dma_req && (starve_cnt_q != LIMIT)) begin
                starve_cnt_d = starve_cnt_q + CW'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the peripheral data bus between core and DMA, one latched transfer at a time (writes 1 bus cycle, reads 2).
// Latency: request seen in IDLE cycle n drives the bus from n+1; done in n+1 (write) or n+2 (read).
// Backpressure: a pending master holds its request until its done pulse; core_wait stalls the core meanwhile.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  core_mode,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    input  logic [1:0]  core_reqw,
    input  logic        core_reqs,
    output logic [31:0] core_rdata,
    output logic        core_done,
    output logic        core_wait,
    input  logic [1:0]  dma_mode,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic [1:0]  dma_reqw,
    input  logic        dma_reqs,
    output logic [31:0] dma_rdata,
    output logic        dma_done,
    output logic [1:0]  bus_mode,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [1:0]  bus_reqw,
    output logic        bus_reqs,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  bus_owner
);

    state_e      state_q, state_d;
    req_t        lat_q, lat_d;
    logic [1:0]  owner_q, owner_d;
    logic [31:0] core_rdata_q, core_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;

    req_t core_in, dma_in;
    logic core_req, dma_req;
    logic grant_stb, grant_core, grant_dma;
    logic xfer_done, in_sample;

    assign core_in  = '{core_mode, core_addr, core_wdata, core_reqw, core_reqs};
    assign dma_in   = '{dma_mode, dma_addr, dma_wdata, dma_reqw, dma_reqs};
    assign core_req = is_req(core_mode);
    assign dma_req  = is_req(dma_mode);

    bus_grant_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .dma_req    (dma_req),
        .grant_stb  (grant_stb),
        .grant_core (grant_core),
        .grant_dma  (grant_dma)
    );

    // Next state: grant from IDLE, reads take an extra SAMPLE cycle before returning to IDLE.
    always_comb begin
        state_d   = state_q;
        grant_stb = 1'b0;
        case (state_q)
            IDLE: begin
                if (core_req || dma_req) begin
                    grant_stb = 1'b1;
                    state_d   = SETUP;
                end
            end
            SETUP:   state_d = (lat_q.mode == BUS_READ) ? SAMPLE : IDLE;
            SAMPLE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch: snapshot the winner at grant so later input changes cannot disturb the transfer.
    always_comb begin
        lat_d   = lat_q;
        owner_d = owner_q;
        if (grant_stb) begin
            lat_d   = grant_core ? core_in : dma_in;
            owner_d = grant_core ? OWN_CORE : OWN_DMA;
        end
    end

    // Bus drive, done pulses and read-data pass-through / hold, all from the latched copy.
    always_comb begin
        bus_mode  = BUS_IDLE;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_reqw  = '0;
        bus_reqs  = 1'b0;
        bus_owner = OWN_NONE;
        if (state_q != IDLE) begin
            bus_mode  = lat_q.mode;
            bus_addr  = lat_q.addr;
            bus_wdata = lat_q.wdata;
            bus_reqw  = lat_q.reqw;
            bus_reqs  = lat_q.reqs;
            bus_owner = owner_q;
        end
        in_sample = (state_q == SAMPLE);
        xfer_done = ((state_q == SETUP) && (lat_q.mode == BUS_WRITE)) || in_sample;
        core_done = xfer_done && (owner_q == OWN_CORE);
        dma_done  = xfer_done && (owner_q == OWN_DMA);

        core_rdata_d = core_rdata_q;
        dma_rdata_d  = dma_rdata_q;
        if (in_sample && (owner_q == OWN_CORE)) core_rdata_d = bus_rdata;
        if (in_sample && (owner_q == OWN_DMA))  dma_rdata_d  = bus_rdata;
        core_rdata = core_rdata_d;
        dma_rdata  = dma_rdata_d;
        core_wait  = core_req && !core_done;
    end

    // State, latch and read-hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            owner_q      <= OWN_NONE;
            core_rdata_q <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            lat_q        <= lat_d;
            owner_q      <= owner_d;
            core_rdata_q <= core_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

endmodule
